sub_nibbles: RTL and testbench
==============================

SUB_NIBBLES -- requirements
Module: sub_nibbles

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port `clk` and reset port `rst` (reset active when rst=0).
REQ-002 The block SHALL have these ports, in this order:
- clk  input  1  rising-edge clock
- rst  input  1  async active-low reset
- cript  input  1  encrypt mode select
- decript  input  1  decrypt mode select
- start  input  1  request to process data_in
- data_in  input  16  state word; four nibbles, nibble k = data_in[4k+3:4k]
- data_out  output  16  substituted word, registered
- busy  output  1  high while a word is being processed
- done  output  1  one-cycle completion pulse
REQ-003 The block SHALL have no parameters; width is fixed at 16 bits.

Function
REQ-004 Forward S-box, in hex, indices 0..F, SHALL be: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
REQ-005 Inverse S-box, in hex, indices 0..F, SHALL be: 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
REQ-006 The FSM SHALL have two states: IDLE and SUB; a 2-bit nibble index idx; an internal 16-bit work register; and a latched mode bit.
REQ-007 In IDLE, start=1 with cript=1 or decript=1 SHALL capture data_in into the work register and set idx=0, busy=1, state=SUB.
REQ-008 The captured mode SHALL be forward when cript=1 (cript wins if both are high); it SHALL be inverse when only decript=1.
REQ-009 In IDLE, start=1 with cript=decript=0 SHALL be ignored: no state change, no done pulse.
REQ-010 In SUB, each clock edge SHALL replace work nibble idx with S-box(nibble) using the latched mode, then increment idx.
REQ-011 Nibbles SHALL be processed in order 0,1,2,3; exactly one nibble per cycle.
REQ-012 On the edge that processes nibble 3, the block SHALL:
- load the full result into data_out;
- set done=1 and busy=0;
- return to IDLE.
REQ-013 Latency SHALL be 4 clocks: done and the new data_out are visible 4 cycles after the edge that samples start.
REQ-014 done SHALL be high for exactly one cycle per completed word and low at all other times.
REQ-015 start, cript, decript and data_in SHALL be ignored while busy=1; the latched mode and captured word govern the whole operation.
REQ-016 data_out SHALL hold its value between completions; intermediate nibbles SHALL never appear on data_out.
REQ-017 start asserted in the same cycle done is high SHALL be accepted (state is IDLE); back-to-back throughput SHALL be one word per 4 cycles.
REQ-018 The idx wrap from 3 to 0 SHALL coincide with the exit from SUB and SHALL NOT trigger any extra substitution.

Reset
REQ-019 rst=0 SHALL immediately, independent of clk, force: state=IDLE, idx=0, work register=0, mode=forward, data_out=16'h0000, busy=0, done=0.
REQ-020 A reset asserted mid-operation SHALL abort the word with no done pulse; after release, the first valid start SHALL behave as from power-up.
REQ-021 After rst goes high, the block SHALL accept start on the first rising edge.

Verification
REQ-022 Reset, then cript=1, start pulse with data_in=16'h0000 -> 4 cycles later done=1, data_out=16'hCCCC, busy high for exactly 4 cycles.
REQ-023 cript=1, data_in=16'h1234 -> data_out=16'h56B9; then decript=1, data_in=16'h56B9 -> data_out=16'h1234.
REQ-024 cript=1, data_in=16'hFEDC, with data_in changed to 16'hFFFF and start re-pulsed during busy -> data_out=16'h2174, single done pulse.
REQ-025 cript=decript=1, data_in=16'h1234 -> 16'h56B9 (forward wins); cript=decript=0 with start -> no busy, no done, data_out unchanged.
REQ-026 Start 16'h1234 forward, assert rst=0 asynchronously after 2 cycles -> data_out=0, busy=0, no done; release, start 16'h0000 forward -> 16'hCCCC after 4 cycles.
REQ-027 Back-to-back words 16'h0000 then 16'h1234, second start in the done cycle -> done pulses 4 cycles apart, outputs 16'hCCCC then 16'h56B9.

Source files
------------

// File: rtl/sub_nibbles.sv
// Nibble-serial 4-bit S-box substitution of a 16-bit word, forward or inverse.
// Result appears 4 clocks after start is accepted; start is ignored while busy.
module sub_nibbles (
  input  logic        clk,
  input  logic        rst,
  input  logic        cript,
  input  logic        decript,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic {S_IDLE = 1'b0, S_SUB = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_idx;
  logic [15:0] r_work;
  logic        r_mode_fwd;
  logic [15:0] r_data_out;
  logic        r_done;

  logic        w_accept;
  logic [3:0]  w_nib;
  logic [3:0]  w_sub;
  logic [15:0] w_work_nxt;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] n);
    case (n)
      4'h0: sbox_fwd = 4'hC;  4'h1: sbox_fwd = 4'h5;
      4'h2: sbox_fwd = 4'h6;  4'h3: sbox_fwd = 4'hB;
      4'h4: sbox_fwd = 4'h9;  4'h5: sbox_fwd = 4'h0;
      4'h6: sbox_fwd = 4'hA;  4'h7: sbox_fwd = 4'hD;
      4'h8: sbox_fwd = 4'h3;  4'h9: sbox_fwd = 4'hE;
      4'hA: sbox_fwd = 4'hF;  4'hB: sbox_fwd = 4'h8;
      4'hC: sbox_fwd = 4'h4;  4'hD: sbox_fwd = 4'h7;
      4'hE: sbox_fwd = 4'h1;  default: sbox_fwd = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] n);
    case (n)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;
      4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;
      4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;
      4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;
      4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  assign w_accept = (r_state == S_IDLE) && start && (cript || decript);
  assign w_nib    = r_work[{r_idx, 2'b00} +: 4];
  assign w_sub    = r_mode_fwd ? sbox_fwd(w_nib) : sbox_inv(w_nib);

  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[{r_idx, 2'b00} +: 4] = w_sub;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SUB;
      S_SUB:   if (r_idx == 2'd3) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == S_SUB);
    done     = r_done;
    data_out = r_data_out;
  end

  // data_out is only written on the final nibble, so partial words never leak out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= 2'd0;
      r_work     <= 16'h0000;
      r_mode_fwd <= 1'b1;
      r_data_out <= 16'h0000;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_work     <= data_in;
          r_idx      <= 2'd0;
          r_mode_fwd <= cript;
        end
      end else begin
        r_work <= w_work_nxt;
        r_idx  <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_data_out <= w_work_nxt;
          r_done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_nibbles.sv
// Scoreboard bench for sub_nibbles: expected words queued at start, checked at done.
module tb_sub_nibbles;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cript = 1'b0;
  logic        decript = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic        busy;
  logic        done;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb_q[$];
  logic [15:0] last_out = 16'h0000;

  logic [3:0] FWD [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  sub_nibbles dut (
    .clk(clk), .rst(rst), .cript(cript), .decript(decript), .start(start),
    .data_in(data_in), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_fwd(input logic [15:0] w);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = FWD[w[4*k +: 4]];
    return r;
  endfunction

  task automatic run_word(input logic c, input logic d, input logic [15:0] din,
                          input logic [15:0] exp_w, input logic interfere, input string name);
    int lat;
    int bc;
    int extra;
    logic [15:0] exp_q;
    @(negedge clk);
    cript = c; decript = d; data_in = din; start = 1'b1;
    sb_q.push_back(exp_w);
    @(posedge clk);
    #1 start = 1'b0; cript = 1'b0; decript = 1'b0; data_in = 16'hA5A5;
    lat = 0; bc = 0;
    @(negedge clk);
    if (busy) bc++;
    while (!done && lat < 20) begin
      if (interfere && lat == 1) begin
        start = 1'b1; cript = 1'b0; decript = 1'b1; data_in = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); lat++;
      @(negedge clk);
      if (!done) begin
        if (busy) bc++;
        checks++;
        if (data_out !== last_out) begin
          errors++; $display("FAIL %s hold: data_out=%h required %h", name, data_out, last_out);
        end
      end
    end
    start = 1'b0;
    exp_q = sb_q.pop_front();
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s timeout: done never seen, required after 4 cycles", name);
    end else begin
      checks++;
      if (data_out !== exp_q) begin
        errors++; $display("FAIL %s data_out: got %h required %h", name, data_out, exp_q);
      end
    end
    last_out = exp_q;
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL %s latency: got %0d required 4", name, lat);
    end
    checks++;
    if (bc !== 4) begin
      errors++; $display("FAIL %s busy_cycles: got %0d required 4", name, bc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done: got %b required 0", name, busy);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL %s single_done: got %0d extra busy/done cycles required 0", name, extra);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (data_out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset: data_out=%h busy=%b done=%b required 0000/0/0", data_out, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_word(1'b1, 1'b0, 16'h0000, 16'hCCCC, 1'b0, "fwd_0000");
    run_word(1'b1, 1'b0, 16'h1234, 16'h56B9, 1'b0, "fwd_1234");
    run_word(1'b0, 1'b1, 16'h56B9, 16'h1234, 1'b0, "inv_56B9");
  endtask

  task automatic test_ignore_while_busy();
    run_word(1'b1, 1'b0, 16'hFEDC, 16'h2174, 1'b1, "busy_ignore");
  endtask

  task automatic test_mode_select();
    int bad;
    run_word(1'b1, 1'b1, 16'h1234, 16'h56B9, 1'b0, "both_modes");
    @(negedge clk);
    cript = 1'b0; decript = 1'b0; data_in = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    repeat (6) begin
      if (busy || done || data_out !== last_out) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL no_mode_start: got %0d bad cycles required 0 (data_out=%h)", bad, data_out);
    end
  endtask

  task automatic test_random_roundtrip();
    logic [15:0] w;
    logic [15:0] f;
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      f = model_fwd(w);
      run_word(1'b1, 1'b0, w, f, 1'b0, "rand_fwd");
      run_word(1'b0, 1'b1, f, w, 1'b0, "rand_inv");
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    @(negedge clk);
    cript = 1'b1; data_in = 16'h1234; start = 1'b1;
    sb_q.push_back(16'h56B9);
    @(posedge clk);
    #1 start = 1'b0; cript = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    void'(sb_q.pop_back());
    #1;
    checks++;
    if (data_out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset: data_out=%h busy=%b done=%b required 0000/0/0", data_out, busy, done);
    end
    last_out = 16'h0000;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_no_done: got %0d bad cycles required 0", bad);
    end
    rst = 1'b1;
    run_word(1'b1, 1'b0, 16'h0000, 16'hCCCC, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] exp_q;
    @(negedge clk);
    cript = 1'b1; data_in = 16'h0000; start = 1'b1;
    sb_q.push_back(16'hCCCC);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    exp_q = sb_q.pop_front();
    checks++;
    if (!done || data_out !== exp_q) begin
      errors++; $display("FAIL b2b_first: done=%b data_out=%h required 1/%h", done, data_out, exp_q);
    end
    cript = 1'b1; data_in = 16'h1234; start = 1'b1;
    sb_q.push_back(16'h56B9);
    @(posedge clk);
    #1 start = 1'b0; cript = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    exp_q = sb_q.pop_front();
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles required 4", lat);
    end
    checks++;
    if (!done || data_out !== exp_q) begin
      errors++; $display("FAIL b2b_second: done=%b data_out=%h required 1/%h", done, data_out, exp_q);
    end
    last_out = exp_q;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_while_busy();
    test_mode_select();
    test_random_roundtrip();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
